fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of decode and immediate extension. Owns the fetch PC, issues single-outstanding word reads to instruction memory, and buffers returned words with their PCs in a small FIFO. Presents `Instr`/`PCD` to decode with a valid/ready handshake. Accepts branch/jump redirects (target = PC + ImmExt computed downstream), flushing stale state.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: instruction buffer entries, power of 2, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `IMemReq`  out  1  one-cycle pulse per read request; memory never back-pressures.
- `IMemAddr`  out  32  word address for the request; bits [1:0] always 0.
- `IMemRValid`  in  1  read response strobe; exactly one per request, ≥1 cycle after request.
- `IMemRData`  in  32  response word, valid with `IMemRValid`.
- `Redirect`  in  1  control-flow change; single-cycle strobe.
- `RedirectPC`  in  32  new fetch address; bits [1:0] ignored, forced to 00.
- `InstrValid`  out  1  buffer head valid.
- `Instr`  out  32  buffered instruction word at head.
- `PCD`  out  32  PC of `Instr`.
- `InstrReady`  in  1  decode accepts head when `InstrValid & InstrReady`.

## Operation

- FSM states: IDLE (no request outstanding), WAIT (one outstanding, response kept), DROP (one outstanding, response discarded).
- `FetchPC` register holds the next address to request.
- `IMemAddr` = `Redirect` ? {RedirectPC[31:2],2'b00} : `FetchPC`.
- Space rule: request may issue when occupancy after this cycle's push/pop, plus 1, is ≤ DEPTH. Combinational from `InstrReady`.
- IDLE: if space, or on `Redirect`, assert `IMemReq`, FetchPC ← IMemAddr+4, go WAIT.
- WAIT, `IMemRValid`, no Redirect: push {FetchPC−4 captured at issue, IMemRData}. If space, issue next request same cycle and stay WAIT; else go IDLE.
- WAIT, Redirect without `IMemRValid`: flush FIFO, FetchPC ← redirect target, go DROP, no request.
- WAIT, Redirect with `IMemRValid`: flush, discard response, issue request to target same cycle, stay WAIT.
- DROP, `IMemRValid`: discard, issue request to FetchPC, go WAIT. Redirect in DROP only updates FetchPC, then stays DROP.
- Redirect with concurrent pop: flush wins; pop has no further effect.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Issued-request PC register (`ReqPC`) travels with the outstanding request and is pushed alongside data.

## Timing

- Reset values: `IMemReq`=0, `InstrValid`=0, `Instr`=0, `PCD`=0, state IDLE, FetchPC=`RESET_PC`, FIFO empty.
- First `IMemReq` appears in the first cycle with `reset` low.
- Response to visible instruction: `IMemRValid` at cycle N gives `InstrValid`=1 at N+1, since FIFO outputs are registered.
- With 1-cycle memory latency and `InstrReady` held high: one instruction per cycle sustained.
- After `Redirect` at cycle N, `InstrValid`=0 at N+1. First redirected instruction appears no earlier than N+2.
- `IMemRValid` while IDLE is illegal; assert in simulation.
- Reset mid-request: state returns to IDLE; any later stale `IMemRValid` is the memory model's responsibility and is tied off in the bench.

## Structure

- `fetch_pkg`: `fetch_state_t` enum (IDLE, WAIT, DROP), `fetch_entry_t` struct {pc[31:0], instr[31:0]}, `PC_INC`=32'd4.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`, DEPTH entries, push/pop/flush. Exposes count, full, empty. Flush has priority over push and pop. Supports simultaneous push and pop when full.

## Test plan

- Reset release, 1-cycle memory, `InstrReady`=1 → requests at 0,4,8,…, one per cycle; `PCD`/`Instr` stream in order, first valid 2 cycles after the first request.
- `InstrReady`=0 for 10 cycles, 1-cycle memory → exactly DEPTH entries buffered, then `IMemReq` stays low. On release, no loss or duplication.
- 3-cycle latency, Redirect to 32'h0000_0100 mid-wait → the old response is discarded. Next request is 0x100; `InstrValid`=0 the cycle after Redirect.
- Redirect coincident with `IMemRValid` and a pop → response dropped, request to target same cycle, FIFO empty next cycle.
- `RESET_PC`=32'hFFFF_FFF8 → fetch PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. Redirect to 32'h0000_0203 → request address 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, buffered entry
// layout and PC arithmetic helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry synchronous FIFO of {pc, instr} with flush.
// Flush beats push and pop; push is accepted when full if a pop frees a slot.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero before any fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, keeps one read outstanding to
// instruction memory and buffers returned words with their PCs for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  output logic         IMemReq,
  output logic [31:0]  IMemAddr,
  input  logic         IMemRValid,
  input  logic [31:0]  IMemRData,
  input  logic         Redirect,
  input  logic [31:0]  RedirectPC,
  output logic         InstrValid,
  output logic [31:0]  Instr,
  output logic [31:0]  PCD,
  input  logic         InstrReady,
  output fetch_state_t state
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]  FetchPC;
  logic [31:0]  ReqPC;
  logic [31:0]  target;
  logic         issue;
  logic         push;
  logic         pop;
  logic         space;
  logic         full;
  logic         empty;
  logic [AW:0]  count;
  int           occ;
  fetch_entry_t head;

  // Decode handshake: the head entry transfers on a cycle where InstrValid and
  // InstrReady are both high; InstrValid never depends on InstrReady.
  assign target     = align_pc(RedirectPC);
  assign IMemAddr   = Redirect ? target : FetchPC;
  assign IMemReq    = issue & ~reset;
  assign pop        = InstrValid & InstrReady;
  assign push       = (state == WAIT) & IMemRValid & ~Redirect;
  assign InstrValid = ~empty;
  assign Instr      = head.instr;
  assign PCD        = head.pc;

  // A new request needs a free slot for its own response after this
  // cycle's push and pop have settled.
  always_comb begin
    occ   = int'(count) + int'(push) - int'(pop);
    space = (occ + 1) <= DEPTH;
    issue = 1'b0;
    case (state)
      IDLE:    issue = Redirect | space;
      WAIT:    issue = IMemRValid & (Redirect | space);
      DROP:    issue = IMemRValid;
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      FetchPC <= RESET_PC;
      ReqPC   <= RESET_PC;
    end else begin
      if (issue) begin
        FetchPC <= IMemAddr + PC_INC;
        ReqPC   <= IMemAddr;
      end else if (Redirect) begin
        FetchPC <= target;
      end
      case (state)
        IDLE: if (issue) state <= WAIT;
        WAIT: begin
          if (IMemRValid)    state <= issue ? WAIT : IDLE;
          else if (Redirect) state <= DROP;
        end
        DROP: if (IMemRValid) state <= WAIT;
        default: state <= IDLE;
      endcase
    end
  end

  // A response with nothing outstanding means the memory model is broken.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(state == IDLE && IMemRValid));
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (Redirect),
    .wdata ('{pc: ReqPC, instr: IMemRData}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with variable latency, queue model of
// the instruction buffer, directed scenarios followed by random traffic.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC1  = 32'h0000_0000;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

  logic         clk = 1'b0;
  logic         reset;
  logic         IMemReq, IMemReq2;
  logic [31:0]  IMemAddr, IMemAddr2;
  logic         IMemRValid, IMemRValid2;
  logic [31:0]  IMemRData, IMemRData2;
  logic         Redirect;
  logic [31:0]  RedirectPC;
  logic         InstrValid, InstrValid2;
  logic [31:0]  Instr, Instr2, PCD, PCD2;
  logic         InstrReady;
  fetch_state_t state, state2;

  int checks = 0;
  int errors = 0;

  logic        s_reset = 1'b1;
  logic        s_redirect = 1'b0;
  logic        s_ready = 1'b0;
  logic [31:0] s_rpc = 32'h0;

  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        mem_pend = 1'b0;
  logic        mem_stale = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic        resp_stale = 1'b0;
  logic [31:0] resp_addr = 32'h0;
  logic        req2_s = 1'b0;
  logic [31:0] addr2_s = 32'h0;
  logic [31:0] exp_req = 32'h0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC1), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemRValid(IMemRValid), .IMemRData(IMemRData), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .InstrValid(InstrValid), .Instr(Instr),
    .PCD(PCD), .InstrReady(InstrReady), .state(state)
  );

  fetch_unit #(.RESET_PC(RPC2), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset), .IMemReq(IMemReq2), .IMemAddr(IMemAddr2),
    .IMemRValid(IMemRValid2), .IMemRData(IMemRData2), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .InstrValid(InstrValid2), .Instr(Instr2),
    .PCD(PCD2), .InstrReady(InstrReady), .state(state2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply staged inputs after the edge, drive memory
  // responses, then check and update the models at the falling edge.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    reset      = s_reset;
    Redirect   = s_redirect;
    RedirectPC = s_rpc;
    InstrReady = s_ready;
    IMemRValid = 1'b0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        IMemRValid = 1'b1;
        IMemRData  = mem_word(mem_addr);
        resp_addr  = mem_addr;
        resp_stale = mem_stale;
        mem_pend   = 1'b0;
      end
    end
    IMemRValid2 = req2_s;
    IMemRData2  = mem_word(addr2_s);
    @(negedge clk);
    req2_s  = IMemReq2;
    addr2_s = IMemAddr2;
    if (reset) begin
      exp_q.delete();
      mem_pend = 1'b0;
      exp_req  = RPC1;
    end else begin
      chk("instr_valid", InstrValid, exp_q.size() > 0);
      if (InstrValid && InstrReady && !Redirect && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pcd", PCD, e);
        chk("instr", Instr, mem_word(e));
      end
      if (IMemRValid && !resp_stale && !Redirect) exp_q.push_back(resp_addr);
      chk("occupancy", exp_q.size() <= DEPTH, 1);
      if (Redirect) begin
        exp_q.delete();
        exp_req = align_pc(RedirectPC);
        if (mem_pend) mem_stale = 1'b1;
      end
      if (IMemReq) begin
        chk("one_outstanding", mem_pend, 0);
        chk("req_addr", IMemAddr, exp_req);
        mem_pend  = 1'b1;
        mem_stale = 1'b0;
        mem_addr  = exp_req;
        mem_cnt   = mem_lat;
        exp_req   = exp_req + 32'd4;
      end
    end
  endtask

  initial begin
    bit found;
    reset = 1'b1; Redirect = 1'b0; RedirectPC = 32'h0; InstrReady = 1'b0;
    IMemRValid = 1'b0; IMemRData = 32'h0; IMemRValid2 = 1'b0; IMemRData2 = 32'h0;

    // Reset values
    repeat (3) tick();
    chk("rst_req", IMemReq, 0);
    chk("rst_valid", InstrValid, 0);
    chk("rst_instr", Instr, 0);
    chk("rst_pcd", PCD, 0);
    chk("rst_state", state, IDLE);
    chk("rst_req2", IMemReq2, 0);

    // Streaming with 1-cycle memory and decode always ready
    s_reset = 1'b0; s_ready = 1'b1;
    tick();
    chk("first_req", IMemReq, 1);
    chk("first_addr", IMemAddr, 32'h0);
    chk("first_addr2", IMemAddr2, RPC2);
    tick();
    chk("no_valid_yet", InstrValid, 0);
    chk("second_addr", IMemAddr, 32'h4);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("stream_valid", InstrValid, 1);
      chk("stream_pcd", PCD, 32'(4 * k));
      chk("stream_req", IMemReq, 1);
      if (k < 4) begin
        chk("wrap_pcd2", PCD2, RPC2 + 32'(4 * k));
        chk("wrap_instr2", Instr2, mem_word(RPC2 + 32'(4 * k)));
      end
    end

    // Decode stalled: buffer fills to DEPTH and requests stop
    s_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_no_req", IMemReq, 0);
    end
    chk("held_count", exp_q.size(), DEPTH);
    chk("held_state", state, IDLE);
    s_ready = 1'b1;
    tick();
    chk("release_req", IMemReq, 1);
    repeat (6) tick();

    // 3-cycle memory, redirect while the response is still in flight
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = mem_pend && mem_cnt == 3;
    end
    chk("lat3_sync", found, 1);
    s_redirect = 1'b1; s_rpc = 32'h0000_0100;
    tick();
    s_redirect = 1'b0;
    chk("redir_noreq", IMemReq, 0);
    tick();
    chk("redir_valid_off", InstrValid, 0);
    chk("redir_drop", state, DROP);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = IMemReq;
    end
    chk("redir_req_seen", found, 1);
    chk("redir_addr", IMemAddr, 32'h0000_0100);
    repeat (8) tick();

    // Redirect coincident with a response and a pop; unaligned target
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = mem_pend && mem_cnt == 1 && exp_q.size() > 0;
    end
    chk("coinc_sync", found, 1);
    s_redirect = 1'b1; s_rpc = 32'h0000_0203;
    tick();
    s_redirect = 1'b0;
    chk("coinc_rvalid", IMemRValid, 1);
    chk("coinc_pop", InstrValid & InstrReady, 1);
    chk("coinc_req", IMemReq, 1);
    chk("coinc_addr", IMemAddr, 32'h0000_0200);
    tick();
    chk("coinc_empty", InstrValid, 0);
    chk("coinc_state", state, WAIT);
    tick();
    chk("coinc_first_pcd", PCD, 32'h0000_0200);

    // Random traffic: stalls, variable latency, redirects anywhere
    for (int i = 0; i < 400; i++) begin
      s_ready    = ($urandom_range(0, 9) < 7);
      s_redirect = ($urandom_range(0, 19) == 0);
      s_rpc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      mem_lat    = $urandom_range(1, 3);
      tick();
    end
    s_redirect = 1'b0; s_ready = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
